// File: rtl/seg7_pkg.sv
// Shared types and the hex segment code table for the 7-segment scan receiver.
package seg7_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    localparam logic [6:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Returns {ok, nibble}; ok=0 for any pattern outside the table.
    function automatic logic [NIBBLE_W:0] seg_to_nibble(input logic [6:0] s);
        logic [NIBBLE_W:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (SEG_CODE[i] == s) r = {1'b1, NIBBLE_W'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low segment pattern to hex nibble decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0]          seg,
    output logic [NIBBLE_W-1:0] nibble,
    output logic                ok
);

    always_comb begin
        {ok, nibble} = seg_to_nibble(seg);
    end

endmodule

// File: rtl/seg7_scan_rx.sv
// Samples a scanned digit-select/segment bus and rebuilds the displayed hex word.
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int NDIG    = 4,
    parameter int STABLE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [NDIG-1:0]     dig_sel,
    input  logic [6:0]          seg,
    output logic [4*NDIG-1:0]   value,
    output logic                value_vld,
    output logic                frame_done,
    output logic                bad_code,
    output logic                stale
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam state_t ARM = (STABLE == 1) ? CAPTURE : SETTLE;

    logic [NDIG-1:0]   sel_q, sel_p, hold_sel, seen, seen_n;
    logic [6:0]        seg_q, seg_p, hold_seg;
    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [TW-1:0]     tcnt;
    logic [4*NDIG-1:0] shadow;
    logic [NIBBLE_W-1:0] dec_nib;
    logic [IW-1:0]     dig_idx;
    logic              one_low, moved, released, do_cap, load_hold;
    logic              dec_ok, full, tmo;

    seg7_decode u_dec (
        .seg    (hold_seg),
        .nibble (dec_nib),
        .ok     (dec_ok)
    );

    always_comb begin
        one_low  = ($countones(~sel_q) == 1);
        moved    = (sel_q != sel_p) || (seg_q != seg_p);
        released = (sel_q != hold_sel) || (seg_q != hold_seg);
        full     = &seen;
        tmo      = (tcnt == TW'(TIMEOUT));
        dig_idx  = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!hold_sel[i]) dig_idx = IW'(i);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (one_low) begin
                    state_n = ARM;
                    cnt_n   = 4'd1;
                end
            end
            SETTLE: begin
                if (moved) begin
                    state_n = one_low ? ARM : IDLE;
                    cnt_n   = 4'd1;
                end else begin
                    cnt_n = cnt + 4'd1;
                    if (cnt >= 4'(STABLE - 1)) state_n = CAPTURE;
                end
            end
            CAPTURE: state_n = HOLD;
            HOLD: begin
                if (released) begin
                    state_n = one_low ? ARM : IDLE;
                    cnt_n   = 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The validated pair is frozen so that HOLD compares against it.
    always_comb begin
        do_cap    = (state == CAPTURE);
        load_hold = (state != CAPTURE) && (state_n == CAPTURE);
        seen_n    = seen;
        if (full || (tmo && !do_cap)) seen_n = '0;
        if (do_cap && dec_ok) seen_n[dig_idx] = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sel_q      <= '0;
            seg_q      <= '0;
            sel_p      <= '0;
            seg_p      <= '0;
            hold_sel   <= '0;
            hold_seg   <= '0;
            seen       <= '0;
            shadow     <= '0;
            tcnt       <= '0;
            value      <= '0;
            value_vld  <= 1'b0;
            frame_done <= 1'b0;
            bad_code   <= 1'b0;
            stale      <= 1'b0;
        end else begin
            sel_q      <= dig_sel;
            seg_q      <= seg;
            sel_p      <= sel_q;
            seg_p      <= seg_q;
            seen       <= seen_n;
            frame_done <= full;
            bad_code   <= do_cap && !dec_ok;
            if (load_hold) begin
                hold_sel <= sel_q;
                hold_seg <= seg_q;
            end
            if (do_cap && dec_ok) shadow[4*dig_idx +: 4] <= dec_nib;
            if (full) begin
                value     <= shadow;
                value_vld <= 1'b1;
            end
            if (do_cap) tcnt <= '0;
            else if (!tmo) tcnt <= tcnt + 1'b1;
            if (tmo && !do_cap) stale <= 1'b1;
            else if (full) stale <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Directed and random scan sequences checked against a frame-level reference model.
module tb_seg7_scan_rx;

    localparam int NDIG    = 4;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 1024;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  dig_sel = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] value;
    logic        value_vld, frame_done, bad_code, stale;

    int total = 0;
    int errs  = 0;

    seg7_scan_rx #(.NDIG(NDIG), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .dig_sel    (dig_sel),
        .seg        (seg),
        .value      (value),
        .value_vld  (value_vld),
        .frame_done (frame_done),
        .bad_code   (bad_code),
        .stale      (stale)
    );

    always #5 Clock = ~Clock;

    logic [6:0] tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int          m_nib [4];
    bit          m_seen [4];
    logic [15:0] m_value;
    bit          m_vld, m_stale, prev_ok;
    logic [3:0]  prev_sel;
    logic [6:0]  prev_seg;
    int          idle, e_fd, e_bad;
    int          nfd, nbad, fd_at;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_nib[i] = 0;
            m_seen[i] = 0;
        end
        m_value = '0;
        m_vld = 0;
        m_stale = 0;
        prev_ok = 0;
        idle = 0;
    endtask

    task automatic model_apply(input logic [3:0] sel, input logic [6:0] sg, input int n);
        int d, nib, lows;
        bit all;
        e_fd = 0;
        e_bad = 0;
        lows = 0;
        d = 0;
        for (int i = 0; i < 4; i++) if (!sel[i]) begin lows++; d = i; end
        if (n >= STABLE && lows == 1 &&
            !(prev_ok && sel == prev_sel && sg == prev_seg)) begin
            nib = -1;
            for (int i = 0; i < 16; i++) if (tbl[i] == sg) nib = i;
            if (nib < 0) e_bad = 1;
            else begin
                m_nib[d] = nib;
                m_seen[d] = 1;
                all = 1;
                for (int i = 0; i < 4; i++) all &= m_seen[i];
                if (all) begin
                    m_value = '0;
                    for (int i = 0; i < 4; i++) begin
                        m_value = m_value + (16'(m_nib[i]) << (4 * i));
                        m_seen[i] = 0;
                    end
                    m_vld = 1;
                    m_stale = 0;
                    e_fd = 1;
                end
            end
            idle = n - STABLE - 1;
        end else begin
            idle += n;
        end
        if (idle > TIMEOUT + 16) begin
            m_stale = 1;
            for (int i = 0; i < 4; i++) m_seen[i] = 0;
        end
        prev_ok = 1;
        prev_sel = sel;
        prev_seg = sg;
    endtask

    task automatic step(input logic [3:0] sel, input logic [6:0] sg, input int n);
        dig_sel = sel;
        seg = sg;
        nfd = 0;
        nbad = 0;
        fd_at = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge Clock);
            #1;
            if (frame_done) begin
                nfd++;
                if (fd_at == 0) fd_at = k;
            end
            if (bad_code) nbad++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] sel, input logic [6:0] sg, input int n);
        model_apply(sel, sg, n);
        step(sel, sg, n);
        chk({tag, ":frame_done"}, 32'(nfd), 32'(e_fd));
        chk({tag, ":bad_code"}, 32'(nbad), 32'(e_bad));
        chk({tag, ":value"}, 32'(value), 32'(m_value));
        chk({tag, ":value_vld"}, 32'(value_vld), 32'(m_vld));
        chk({tag, ":stale"}, 32'(stale), 32'(m_stale));
        if (e_fd != 0) chk({tag, ":latency"}, 32'(fd_at), 32'(STABLE + 3));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        dig_sel = 4'hF;
        seg = 7'h7F;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst:value", 32'(value), 32'h0);
        chk("rst:flags", {28'h0, value_vld, frame_done, bad_code, stale}, 32'h0);
        Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [3:0] rs;
        logic [6:0] rg;
        int         rn;

        @(posedge Clock);
        #1;
        do_reset();

        run("t1d0", 4'b1110, 7'h79, 8);
        run("t1d1", 4'b1101, 7'h24, 8);
        run("t1d2", 4'b1011, 7'h30, 8);
        run("t1d3", 4'b0111, 7'h19, 8);
        chk("t1:value", 32'(value), 32'h4321);

        run("t2d0", 4'b1110, 7'h12, 8);
        run("t2d1", 4'b1101, 7'h02, 8);
        run("t2blank", 4'b1011, 7'h7F, 8);
        run("t2d3", 4'b0111, 7'h18, 8);
        run("t2d2", 4'b1011, 7'h78, 8);

        run("t3d1", 4'b1101, 7'h24, 8);
        run("t3d2", 4'b1011, 7'h30, 8);
        run("t3d3", 4'b0111, 7'h19, 8);
        for (int g = 0; g < 4; g++)
            run("t3glitch", 4'b1110, (g % 2 == 0) ? 7'h0E : 7'h06, STABLE - 1);
        run("t3d0", 4'b1110, 7'h0E, 8);
        chk("t3:value", 32'(value), 32'h432F);

        run("t4multi", 4'b0011, 7'h79, 20);

        run("t5d0", 4'b1110, 7'h78, 8);
        run("t5d1", 4'b1101, 7'h78, 8);
        run("t5idle", 4'b1111, 7'h7F, TIMEOUT + 80);
        run("t5d2", 4'b1011, 7'h19, 8);
        run("t5d3", 4'b0111, 7'h00, 8);
        run("t5d0b", 4'b1110, 7'h79, 8);
        run("t5d1b", 4'b1101, 7'h24, 8);
        chk("t5:value", 32'(value), 32'h8421);

        run("t6d0", 4'b1110, 7'h08, 8);
        run("t6d1", 4'b1101, 7'h03, 8);
        run("t6d2", 4'b1011, 7'h46, 8);
        do_reset();
        run("t6d3", 4'b0111, 7'h21, 8);
        run("t6d0b", 4'b1110, 7'h08, 8);
        run("t6d1b", 4'b1101, 7'h03, 8);
        run("t6d2b", 4'b1011, 7'h46, 8);
        run("t6d3b", 4'b0111, 7'h06, 8);

        for (int s = 0; s < 48; s++) begin
            do begin
                rs = ($urandom_range(0, 7) == 0) ? 4'hF : ~(4'b1 << $urandom_range(0, 3));
                rg = ($urandom_range(0, 3) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 15)];
            end while (rs == prev_sel && rg == prev_seg);
            rn = ($urandom_range(0, 3) == 0) ? 2 : 8;
            run("rand", rs, rg, rn);
        end

        $display("test done: total=%0d bad=%0d", total, errs);
        $finish;
    end

endmodule
